// File: rtl/datapath_seq.sv
// ---------------------------------------------------------------------------
// datapath_seq
//
// Self-sequencing register-to-register datapath. A command is accepted on a
// cmd_valid/cmd_ready handshake. An internal FSM then walks it through
// register read (A, then B), shift/ALU, status update and writeback. No
// per-cycle external control is needed.
//
// Parameters
//   W   datapath width (W >= 4)
//   AW  register address width; the register file holds 2**AW words
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   cmd_valid/ready     command handshake; ready only while idle
//   cmd_rd/rn/rm        destination / A-source / B-source register
//   cmd_aluop           00 ADD, 01 SUB (A-B), 10 AND, 11 NOT B
//   cmd_shift           B shift: 00 none, 01 lsl1, 10 lsr1, 11 asr1
//   cmd_asel            force A operand to zero
//   cmd_bsel            use cmd_imm as B operand (shifter bypassed)
//   cmd_imm             immediate
//   cmd_movi            write cmd_imm to rd, skipping the ALU
//   cmd_wb              write the ALU result to rd
//   cmd_loads           update status flags
//   done                one-cycle completion pulse
//   datapath_out        result (C) register
//   Z_out, N_out, V_out status flags
//
// Build option
//   DATAPATH_SEQ_NV_EN  when defined, N and V are computed and stored next
//                       to Z. Otherwise only Z exists, and N_out/V_out are 0.
// ---------------------------------------------------------------------------
module datapath_seq #(
    parameter int W  = 16,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [AW-1:0] cmd_rd,
    input  logic [AW-1:0] cmd_rn,
    input  logic [AW-1:0] cmd_rm,
    input  logic [1:0]    cmd_aluop,
    input  logic [1:0]    cmd_shift,
    input  logic          cmd_asel,
    input  logic          cmd_bsel,
    input  logic [W-1:0]  cmd_imm,
    input  logic          cmd_movi,
    input  logic          cmd_wb,
    input  logic          cmd_loads,
    output logic          done,
    output logic [W-1:0]  datapath_out,
    output logic          Z_out,
    output logic          N_out,
    output logic          V_out
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOADA = 3'd1,
        S_LOADB = 3'd2,
        S_EXEC  = 3'd3,
        S_WB    = 3'd4
    } state_t;

    localparam int NREGS = 2 ** AW;

    // B operand shifter
    function automatic logic signed [W-1:0] shift_b(
        input logic signed [W-1:0] b,
        input logic [1:0]          sh
    );
        case (sh)
            2'b01:   shift_b = b <<< 1;
            2'b10:   shift_b = $signed($unsigned(b) >> 1);
            2'b11:   shift_b = b >>> 1;
            default: shift_b = b;
        endcase
    endfunction

    // ALU, arithmetic wraps mod 2**W
    function automatic logic signed [W-1:0] alu_f(
        input logic signed [W-1:0] a,
        input logic signed [W-1:0] b,
        input logic [1:0]          op
    );
        case (op)
            2'b00:   alu_f = a + b;
            2'b01:   alu_f = a - b;
            2'b10:   alu_f = a & b;
            default: alu_f = ~b;
        endcase
    endfunction

`ifdef DATAPATH_SEQ_NV_EN
    // Signed overflow: operands that agree in sign (ADD) or differ (SUB)
    // produce a result whose sign differs from A.
    function automatic logic ovf_f(
        input logic signed [W-1:0] a,
        input logic signed [W-1:0] b,
        input logic signed [W-1:0] r,
        input logic [1:0]          op
    );
        case (op)
            2'b00:   ovf_f = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            2'b01:   ovf_f = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            default: ovf_f = 1'b0;
        endcase
    endfunction
`endif

    state_t state, state_next;
    logic   done_next;
    logic   accept;

    logic [AW-1:0]        rd_p0, rn_p0, rm_p0;
    logic [1:0]           aluop_p0, shift_p0;
    logic                 asel_p0, bsel_p0, movi_p0, wb_p0, loads_p0;
    logic signed [W-1:0]  imm_p0;

    logic signed [W-1:0]  a_p1, b_p1;
    logic signed [W-1:0]  ain_p1, bin_p1, alu_p1;

    logic signed [W-1:0]  c_p2;
    logic                 z_p2;
`ifdef DATAPATH_SEQ_NV_EN
    logic                 n_p2, v_p2;
`endif

    logic signed [W-1:0]  regs [0:NREGS-1];

    assign cmd_ready = (state == S_IDLE);
    assign accept    = cmd_valid & cmd_ready;

    // Sequencer
    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        unique case (state)
            S_IDLE:  if (accept) state_next = cmd_movi ? S_WB : S_LOADA;
            S_LOADA: state_next = S_LOADB;
            S_LOADB: state_next = S_EXEC;
            S_EXEC: begin
                state_next = wb_p0 ? S_WB : S_IDLE;
                done_next  = ~wb_p0;
            end
            S_WB: begin
                state_next = S_IDLE;
                done_next  = 1'b1;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            done  <= done_next;
        end
    end

    // ---- stage p0: command latch ----
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_p0    <= '0;
            rn_p0    <= '0;
            rm_p0    <= '0;
            aluop_p0 <= '0;
            shift_p0 <= '0;
            asel_p0  <= 1'b0;
            bsel_p0  <= 1'b0;
            movi_p0  <= 1'b0;
            wb_p0    <= 1'b0;
            loads_p0 <= 1'b0;
            imm_p0   <= '0;
        end else if (accept) begin
            rd_p0    <= cmd_rd;
            rn_p0    <= cmd_rn;
            rm_p0    <= cmd_rm;
            aluop_p0 <= cmd_aluop;
            shift_p0 <= cmd_shift;
            asel_p0  <= cmd_asel;
            bsel_p0  <= cmd_bsel;
            movi_p0  <= cmd_movi;
            wb_p0    <= cmd_wb;
            loads_p0 <= cmd_loads;
            imm_p0   <= cmd_imm;
        end
    end

    // ---- stage p1: operand select and ALU ----
    always_comb begin
        ain_p1 = asel_p0 ? '0 : a_p1;
        bin_p1 = bsel_p0 ? imm_p0 : shift_b(b_p1, shift_p0);
        alu_p1 = alu_f(ain_p1, bin_p1, aluop_p0);
    end

    // ---- stage p2: result, status and register file ----
    // Register reads are asynchronous and happen in LOADA/LOADB, always
    // before the WB write of the same command, so rd == rn/rm sees old data.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_p1 <= '0;
            b_p1 <= '0;
            c_p2 <= '0;
            z_p2 <= 1'b0;
`ifdef DATAPATH_SEQ_NV_EN
            n_p2 <= 1'b0;
            v_p2 <= 1'b0;
`endif
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            if (state == S_LOADA) a_p1 <= regs[rn_p0];
            if (state == S_LOADB) b_p1 <= regs[rm_p0];
            if (state == S_EXEC) begin
                c_p2 <= alu_p1;
                if (loads_p0) begin
                    z_p2 <= (alu_p1 == '0);
`ifdef DATAPATH_SEQ_NV_EN
                    n_p2 <= alu_p1[W-1];
                    v_p2 <= ovf_f(ain_p1, bin_p1, alu_p1, aluop_p0);
`endif
                end
            end
            // movi writes the immediate directly and leaves C and flags alone
            if (state == S_WB) regs[rd_p0] <= movi_p0 ? imm_p0 : c_p2;
        end
    end

    assign datapath_out = c_p2;
    assign Z_out        = z_p2;
`ifdef DATAPATH_SEQ_NV_EN
    assign N_out        = n_p2;
    assign V_out        = v_p2;
`else
    assign N_out        = 1'b0;
    assign V_out        = 1'b0;
`endif

endmodule

// File: tb/tb_datapath_seq.sv
// ---------------------------------------------------------------------------
// tb_datapath_seq
//
// Self-checking bench for datapath_seq (W=16, AW=3). It runs a table of
// directed commands with hand-computed results, then the reset corner
// cases, then random commands checked against an arithmetic reference
// model. Register contents are observed through ALU read-back commands
// (asel=1, ADD, no shift), so B passes straight through to the C register.
// ---------------------------------------------------------------------------
module tb_datapath_seq;

    localparam int W  = 16;
    localparam int AW = 3;
`ifdef DATAPATH_SEQ_NV_EN
    localparam bit NV_EN = 1'b1;
`else
    localparam bit NV_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_rd, cmd_rn, cmd_rm;
    logic [1:0]    cmd_aluop, cmd_shift;
    logic          cmd_asel, cmd_bsel;
    logic [W-1:0]  cmd_imm;
    logic          cmd_movi, cmd_wb, cmd_loads;
    logic          done;
    logic [W-1:0]  datapath_out;
    logic          Z_out, N_out, V_out;

    datapath_seq #(.W(W), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_rd(cmd_rd), .cmd_rn(cmd_rn), .cmd_rm(cmd_rm),
        .cmd_aluop(cmd_aluop), .cmd_shift(cmd_shift),
        .cmd_asel(cmd_asel), .cmd_bsel(cmd_bsel), .cmd_imm(cmd_imm),
        .cmd_movi(cmd_movi), .cmd_wb(cmd_wb), .cmd_loads(cmd_loads),
        .done(done), .datapath_out(datapath_out),
        .Z_out(Z_out), .N_out(N_out), .V_out(V_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  rd, rn, rm;
        logic [1:0]  op, sh;
        logic        asel, bsel, movi, wb, loads, hold;
        logic [15:0] imm;
        int          e_out, e_z, e_n, e_v, e_lat;
    } vec_t;

    int n_pass  = 0;
    int n_total = 0;

    // reference model state
    int mr [8];
    int mc;
    int mz, mn, mv;

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    function automatic vec_t mk(input int rd, rn, rm, op, sh, asel, bsel,
                                input int movi, wb, loads, hold, imm,
                                input int eo, ez, en, ev, lat);
        vec_t v;
        v.rd = 3'(rd); v.rn = 3'(rn); v.rm = 3'(rm);
        v.op = 2'(op); v.sh = 2'(sh);
        v.asel = 1'(asel); v.bsel = 1'(bsel); v.movi = 1'(movi);
        v.wb = 1'(wb); v.loads = 1'(loads); v.hold = 1'(hold);
        v.imm = 16'(imm);
        v.e_out = eo; v.e_z = ez; v.e_n = en; v.e_v = ev; v.e_lat = lat;
        return v;
    endfunction

    // register read-back: 0 + R[r] into C, no write, flags untouched
    function automatic vec_t rb(input int r, eo, ez, en, ev);
        return mk(0, 0, r, 0, 0, 1, 0, 0, 0, 0, 0, 0, eo, ez, en, ev, 3);
    endfunction

    function automatic int to_signed16(input int x);
        return (x >= 32768) ? x - 65536 : x;
    endfunction

    // Behavioural model: computes the command's effect on the register
    // file, C and the flags with plain integer arithmetic.
    task automatic model_apply(input vec_t c);
        int a, braw, b, r, s, ov;
        if (c.movi) begin
            mr[c.rd] = int'(c.imm);
            return;
        end
        a    = c.asel ? 0 : mr[c.rn];
        braw = mr[c.rm];
        case (c.sh)
            2'd1:    b = (braw * 2) % 65536;
            2'd2:    b = braw / 2;
            2'd3:    b = braw / 2 + ((braw >= 32768) ? 32768 : 0);
            default: b = braw;
        endcase
        if (c.bsel) b = int'(c.imm);
        ov = 0;
        case (c.op)
            2'd0: begin
                r = (a + b) % 65536;
                s = to_signed16(a) + to_signed16(b);
                ov = (s > 32767 || s < -32768) ? 1 : 0;
            end
            2'd1: begin
                r = (a - b + 65536) % 65536;
                s = to_signed16(a) - to_signed16(b);
                ov = (s > 32767 || s < -32768) ? 1 : 0;
            end
            2'd2:    r = a & b;
            default: r = 65535 - b;
        endcase
        mc = r;
        if (c.loads) begin
            mz = (r == 0) ? 1 : 0;
            mn = (r >= 32768) ? 1 : 0;
            mv = ov;
        end
        if (c.wb) mr[c.rd] = r;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mr[i] = 0;
        mc = 0; mz = 0; mn = 0; mv = 0;
    endtask

    // Issue one command and wait (bounded) for done. lat = -1 if no done.
    task automatic issue(input vec_t c, output int lat, output int o,
                         output int z, output int n, output int v,
                         output int rdy);
        @(negedge clk);
        cmd_rd = c.rd; cmd_rn = c.rn; cmd_rm = c.rm;
        cmd_aluop = c.op; cmd_shift = c.sh;
        cmd_asel = c.asel; cmd_bsel = c.bsel; cmd_imm = c.imm;
        cmd_movi = c.movi; cmd_wb = c.wb; cmd_loads = c.loads;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        if (!c.hold) cmd_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!done && lat < 20);
        cmd_valid = 1'b0;
        if (!done) lat = -1;
        o = int'(datapath_out);
        z = int'(Z_out); n = int'(N_out); v = int'(V_out);
        rdy = int'(cmd_ready);
    endtask

    vec_t tbl[$];

    initial begin
        int lat, o, z, n, v, rdy, extra;
        vec_t c;

        reset = 1'b1; cmd_valid = 1'b0;
        cmd_rd = '0; cmd_rn = '0; cmd_rm = '0; cmd_aluop = '0; cmd_shift = '0;
        cmd_asel = 1'b0; cmd_bsel = 1'b0; cmd_imm = '0;
        cmd_movi = 1'b0; cmd_wb = 1'b0; cmd_loads = 1'b0;
        model_reset();

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_ready", int'(cmd_ready), 1);
        chk("rst_done",  int'(done), 0);
        chk("rst_out",   int'(datapath_out), 0);
        chk("rst_z",     int'(Z_out), 0);
        chk("rst_n",     int'(N_out), 0);
        chk("rst_v",     int'(V_out), 0);

        //         rd rn rm op sh as bs mv wb ld hd imm      out    z n v lat
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 16'h0007, 16'h0000, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 16'h0002, 16'h0000, 0, 0, 0, 1));
        tbl.push_back(mk(2, 0, 1, 0, 1, 0, 0, 0, 1, 1, 0, 0,        16'h000B, 0, 0, 0, 4));
        tbl.push_back(mk(3, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0,        16'h0000, 1, 0, 0, 4));
        tbl.push_back(mk(4, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 16'h7FFF, 16'h0000, 1, 0, 0, 1));
        tbl.push_back(mk(5, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 16'h0001, 16'h0000, 1, 0, 0, 1));
        tbl.push_back(mk(6, 4, 5, 0, 0, 0, 0, 0, 1, 1, 0, 0,        16'h8000, 0, 1, 1, 4));
        // compare: no wb, no flag load, cmd_valid held through busy cycles
        tbl.push_back(mk(2, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0,        16'h0005, 0, 1, 1, 3));
        tbl.push_back(rb(2, 16'h000B, 0, 1, 1));
        tbl.push_back(rb(3, 16'h0000, 0, 1, 1));
        tbl.push_back(rb(6, 16'h8000, 0, 1, 1));
        tbl.push_back(rb(0, 16'h0007, 0, 1, 1));
        tbl.push_back(rb(1, 16'h0002, 0, 1, 1));
        // NOT R1, AND with immediate, ASR/LSR of 0x8000, SUB overflow
        tbl.push_back(mk(0, 0, 1, 3, 0, 0, 0, 0, 0, 1, 0, 0,        16'hFFFD, 0, 1, 0, 3));
        tbl.push_back(mk(0, 4, 0, 2, 0, 0, 1, 0, 0, 1, 0, 16'h00F0, 16'h00F0, 0, 0, 0, 3));
        tbl.push_back(mk(0, 0, 6, 0, 3, 1, 0, 0, 0, 1, 0, 0,        16'hC000, 0, 1, 0, 3));
        tbl.push_back(mk(0, 0, 6, 0, 2, 1, 0, 0, 0, 1, 0, 0,        16'h4000, 0, 0, 0, 3));
        tbl.push_back(mk(0, 6, 5, 1, 0, 0, 0, 0, 0, 1, 0, 0,        16'h7FFF, 0, 0, 1, 3));

        foreach (tbl[i]) begin
            issue(tbl[i], lat, o, z, n, v, rdy);
            chk($sformatf("tbl%0d_lat", i), lat, tbl[i].e_lat);
            chk($sformatf("tbl%0d_out", i), o, tbl[i].e_out);
            chk($sformatf("tbl%0d_z", i), z, tbl[i].e_z);
            chk($sformatf("tbl%0d_n", i), n, NV_EN ? tbl[i].e_n : 0);
            chk($sformatf("tbl%0d_v", i), v, NV_EN ? tbl[i].e_v : 0);
            chk($sformatf("tbl%0d_ready", i), rdy, 1);
        end

        // Reset during EXEC of ADD into R7: command aborted
        @(negedge clk);
        cmd_rd = 3'd7; cmd_rn = 3'd0; cmd_rm = 3'd1; cmd_aluop = 2'd0;
        cmd_shift = 2'd0; cmd_asel = 1'b0; cmd_bsel = 1'b0; cmd_imm = '0;
        cmd_movi = 1'b0; cmd_wb = 1'b1; cmd_loads = 1'b1;
        cmd_valid = 1'b1;
        @(posedge clk); #1 cmd_valid = 1'b0;   // accepted, now LOADA
        @(posedge clk);                        // LOADB
        @(posedge clk); #1;                    // EXEC
        chk("midrst_busy", int'(cmd_ready), 0);
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        chk("midrst_ready", int'(cmd_ready), 1);
        chk("midrst_out",   int'(datapath_out), 0);
        chk("midrst_done",  int'(done), 0);
        chk("midrst_z",     int'(Z_out), 0);
        extra = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        chk("midrst_no_done", extra, 0);
        model_reset();
        issue(rb(7, 0, 0, 0, 0), lat, o, z, n, v, rdy);
        chk("midrst_r7", o, 0);
        chk("midrst_r7_lat", lat, 3);

        // Reset and cmd_valid together: reset wins, movi not accepted
        @(negedge clk);
        cmd_rd = 3'd1; cmd_imm = 16'h1234; cmd_movi = 1'b1; cmd_wb = 1'b0;
        cmd_loads = 1'b0; cmd_valid = 1'b1; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; cmd_valid = 1'b0; cmd_movi = 1'b0;
        chk("rstvld_ready", int'(cmd_ready), 1);
        @(posedge clk); #1;
        chk("rstvld_done", int'(done), 0);
        issue(rb(1, 0, 0, 0, 0), lat, o, z, n, v, rdy);
        chk("rstvld_r1", o, 0);

        // Random commands against the reference model
        model_reset();
        for (int k = 0; k < 60; k++) begin
            c.rd = 3'($urandom_range(0, 7));
            c.rn = 3'($urandom_range(0, 7));
            c.rm = 3'($urandom_range(0, 7));
            c.op = 2'($urandom_range(0, 3));
            c.sh = 2'($urandom_range(0, 3));
            c.asel = 1'($urandom_range(0, 3) == 0);
            c.bsel = 1'($urandom_range(0, 3) == 0);
            c.movi = 1'($urandom_range(0, 3) == 0);
            c.wb = 1'($urandom_range(0, 1));
            c.loads = 1'($urandom_range(0, 1));
            c.hold = 1'($urandom_range(0, 1));
            c.imm = 16'($urandom);
            c.e_lat = c.movi ? 1 : (c.wb ? 4 : 3);
            model_apply(c);
            issue(c, lat, o, z, n, v, rdy);
            chk($sformatf("rnd%0d_lat", k), lat, c.e_lat);
            chk($sformatf("rnd%0d_out", k), o, mc);
            chk($sformatf("rnd%0d_z", k), z, mz);
            chk($sformatf("rnd%0d_n", k), n, NV_EN ? mn : 0);
            chk($sformatf("rnd%0d_v", k), v, NV_EN ? mv : 0);
        end

        // Final sweep of the register file against the model
        for (int r = 0; r < 8; r++) begin
            model_apply(rb(r, 0, 0, 0, 0));
            issue(rb(r, 0, 0, 0, 0), lat, o, z, n, v, rdy);
            chk($sformatf("final_r%0d", r), o, mc);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/datapath_seq.md
# datapath_seq

Parametrised, self-sequencing successor to the hand-driven datapath. It accepts one register-to-register operation per valid/ready handshake and walks it through register read, shift, ALU, status update and writeback with an internal state machine; no per-cycle external control. It sits between the instruction decoder and the register-file/ALU resources, and exposes the result register and status flags to the controller.

## Interface
- W, 16: datapath width; W ≥ 4.
- AW, 3: register address width; register file holds 2**AW registers of W bits.

Ports (name, direction, width, meaning):
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block idle and able to accept a command.
- cmd_rd / cmd_rn / cmd_rm  in  AW  destination / A-source / B-source register.
- cmd_aluop  in  2  00 ADD, 01 SUB (A−B), 10 AND, 11 NOT B.
- cmd_shift  in  2  applied to the B register: 00 none, 01 left 1, 10 logical right 1, 11 arithmetic right 1.
- cmd_asel  in  1  1 forces A operand to 0.
- cmd_bsel  in  1  1 selects cmd_imm as B operand; the shifter is bypassed.
- cmd_imm  in  W  immediate value.
- cmd_movi  in  1  write cmd_imm straight to rd; skips the ALU.
- cmd_wb  in  1  write the ALU result to rd.
- cmd_loads  in  1  update the status flags.
- done  out  1  one-cycle pulse: command complete.
- datapath_out  out  W  C (result) register.
- Z_out, N_out, V_out  out  1 each  status flags.

## Operation
- Command fields are latched when cmd_valid & cmd_ready are sampled high at a rising edge. Fields at any other time are ignored. There is no queue; cmd_valid held while busy has no effect.
- States and transitions:
  - IDLE: cmd_ready=1. On accept, go to WB if movi, otherwise LOADA.
  - LOADA: A ← R[rn]. Go to LOADB.
  - LOADB: B ← R[rm]. Go to EXEC.
  - EXEC: C ← ALU(Ain, Bin). Flags load if loads. Go to WB if wb, otherwise IDLE.
  - WB: R[rd] ← C (or imm if movi). Go to IDLE.
- Operand selection:
  - Ain = asel ? 0 : A.
  - Bin = bsel ? imm : shift(B).
- Arithmetic is mod 2**W. AND and NOT B are bitwise.
- Flags:
  - Z = (result == 0).
  - N = result[W−1].
  - V = signed overflow for ADD/SUB; 0 for AND/NOT.
- movi never touches C or the flags.
- Register file: asynchronous read, write on the clock edge. rd may equal rn or rm; reads occur in LOADA/LOADB, so they see pre-write values.
- done is registered. It is high for the single cycle after the final state's edge, coincident with cmd_ready=1.

## Timing
- Accept at edge 0. Latency to done:
  - ALU with wb: 4 cycles (done high after edge 4).
  - ALU without wb: 3 cycles.
  - movi: 1 cycle.
- Earliest next accept is the edge ending the done cycle. Back-to-back commands are therefore separated by at least one IDLE cycle.
- Reset values (registered at the reset edge): state IDLE, cmd_ready=1 after reset deasserts, done=0, datapath_out=0, all flags 0, A=B=0, all registers 0.
- Reset mid-operation aborts the command: no register write and no done pulse.
- Reset and cmd_valid in the same cycle: reset wins; the command is not accepted.

## Configuration
- DATAPATH_SEQ_NV_EN defined:
  - N and V are computed and stored in the status register with Z.
  - N_out and V_out reflect them.
- Not defined:
  - The status register holds Z only.
  - N_out and V_out are tied to 0; no N/V logic is synthesised.
- Z behaviour and all latencies are identical in both builds.

## Test plan
- Reset 2 cycles, then movi R0=7 and movi R1=2: each done 1 cycle after accept; R0=0x0007, R1=0x0002; datapath_out stays 0x0000.
- ADD rd=R2, rn=R0, rm=R1, shift=01, wb=1, loads=1: done exactly 4 cycles after accept; datapath_out=0x000B, R2=0x000B, Z_out=0.
- SUB rd=R3, rn=R0, rm=R0, wb=1, loads=1: datapath_out=0x0000, Z_out=1; with the macro, N_out=0 and V_out=0.
- movi R4=0x7FFF, movi R5=0x0001, then ADD R6=R4+R5 with loads: datapath_out=0x8000, Z_out=0.
  - With the macro: N_out=1, V_out=1.
  - Without it: N_out=V_out=0.
- Compare: SUB R0−R1 with wb=0, loads=0. Done after 3 cycles; datapath_out=0x0005; flags unchanged; rd unchanged. cmd_valid held high throughout busy cycles accepts nothing extra.
- Assert reset for one cycle during EXEC of ADD into R7: R7 stays 0x0000, no done pulse, cmd_ready=1 and datapath_out=0x0000 in the cycle after reset deasserts.
